// File: rtl/switch_level_ramp.sv
// Switch bank to ramped level: two-flop synchroniser, debounce, level lookup,
// and a slew-limited output that steps toward the selected level on prescaler ticks.
module switch_level_ramp #(
    parameter int SW_WIDTH        = 2,
    parameter int VAL_WIDTH       = 8,
    parameter int MAX_VALUE       = 100,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 2,
    parameter int STEP            = 5
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic [SW_WIDTH-1:0]  iSW,
    input  logic                 iEn,
    output logic [VAL_WIDTH-1:0] oValue,
    output logic [SW_WIDTH-1:0]  oCode,
    output logic                 oChanged,
    output logic                 oSettled
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LVL_W = VAL_WIDTH + SW_WIDTH + 1;
    localparam int AW    = VAL_WIDTH + 1;

    logic [SW_WIDTH-1:0]  sync1_q, sync2_q;
    logic [SW_WIDTH-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SW_WIDTH-1:0]  code_q, code_d;
    logic                 changed_q, changed_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [VAL_WIDTH-1:0] target_q, target_d;
    logic [VAL_WIDTH-1:0] value_q, value_d;

    logic [SW_WIDTH-1:0]  sw_s;
    logic                 tick;
    logic [AW-1:0]        v_ext, t_ext, up_sum;

    function automatic logic [VAL_WIDTH-1:0] level_of(input logic [SW_WIDTH-1:0] c);
        logic [LVL_W-1:0] prod;
        prod = (LVL_W'(c) + LVL_W'(1)) * LVL_W'(MAX_VALUE);
        return VAL_WIDTH'(prod >> SW_WIDTH);
    endfunction

    assign sw_s = sync2_q;

    // Debounce: the candidate follows oCode while the input matches it, so any
    // excursion away always starts a fresh count of DEBOUNCE_CYCLES samples.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        changed_d = 1'b0;
        if (sw_s == code_q) begin
            cnt_d  = '0;
            cand_d = code_q;
        end else if (DEBOUNCE_CYCLES == 1) begin
            cand_d    = sw_s;
            code_d    = sw_s;
            cnt_d     = '0;
            changed_d = 1'b1;
        end else if (sw_s != cand_q) begin
            cand_d = sw_s;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            code_d    = cand_q;
            cnt_d     = '0;
            changed_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign target_d = iEn ? level_of(code_q) : '0;

    assign tick  = (div_q == DIV_W'(TICK_DIV - 1));
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    // Ramp math is one bit wider than the output so neither direction can wrap.
    assign v_ext  = AW'(value_q);
    assign t_ext  = AW'(target_q);
    assign up_sum = v_ext + AW'(STEP);

    always_comb begin
        value_d = value_q;
        if (tick) begin
            if (v_ext < t_ext) begin
                value_d = (up_sum > t_ext) ? target_q : up_sum[VAL_WIDTH-1:0];
            end else if (v_ext > t_ext) begin
                value_d = (v_ext > t_ext + AW'(STEP)) ? VAL_WIDTH'(v_ext - AW'(STEP)) : target_q;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            changed_q <= 1'b0;
            div_q     <= '0;
            target_q  <= '0;
            value_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            sync1_q   <= iSW;
            sync2_q   <= sync1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            changed_q <= changed_d;
            div_q     <= div_d;
            target_q  <= target_d;
            value_q   <= value_d;
        end
    end

    assign oValue   = value_q;
    assign oCode    = code_q;
    assign oChanged = changed_q;
    assign oSettled = (value_q == target_q);

endmodule
